// File: rtl/imem_load_arbiter.sv
// Purpose : shares IMEM port A between CPU stores and a byte-stream program loader
//           that packs bytes big-endian into words written from a base address.
// Latency : port mux is combinational (0 cycles); a loader word is written in the
//           first cycle after its 4th byte in which the CPU is not storing.
// Backpressure: ld_ready is high only while collecting bytes; the CPU is never stalled,
//           and a pending loader write waits (counted in conflict_cnt) while cpu_we != 0.
// Ports   : clk/rst (async active-high); cpu_we/cpu_addr/cpu_din CPU store side;
//           ld_start/ld_base/ld_count/ld_byte/ld_valid/ld_ready loader side;
//           ld_busy/ld_done/cpu_hold status; imem_wea/imem_addra/imem_dina IMEM port A;
//           conflict_cnt saturating count of cycles a loader write was deferred.
module imem_load_arbiter #(
  parameter int ADDR_W   = 12,
  parameter bit HOLD_CPU = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_din,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_count,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              cpu_hold,
  output logic [3:0]        imem_wea,
  output logic [ADDR_W-1:0] imem_addra,
  output logic [31:0]       imem_dina,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PEND    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]  WIDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       word_q;
  logic [CNT_W-1:0]  conflict_q;

  logic              cpu_wr;
  logic              ld_wr;
  logic              byte_xfer;
  logic              last_word;
  logic [ADDR_W-1:0] ld_addr;

  assign cpu_wr    = |cpu_we;
  // Loader owns the port only when a word is pending and the CPU is idle.
  assign ld_wr     = (state_q == S_PEND) && !cpu_wr;
  assign byte_xfer = (state_q == S_COLLECT) && ld_valid;
  assign last_word = ((word_idx_q + WIDX_ONE) == count_q);
  // Truncating add gives the modulo-2^ADDR_W wrap for free.
  assign ld_addr   = base_q + word_idx_q[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      conflict_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ld_start) begin
            base_q     <= ld_base;
            count_q    <= ld_count;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            state_q    <= (ld_count == '0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (byte_xfer) begin
            case (byte_idx_q)
              2'd0:    word_q[31:24] <= ld_byte;
              2'd1:    word_q[23:16] <= ld_byte;
              2'd2:    word_q[15:8]  <= ld_byte;
              default: word_q[7:0]   <= ld_byte;
            endcase
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_q <= S_PEND;
            end
          end
        end
        S_PEND: begin
          if (cpu_wr) begin
            if (conflict_q != '1) begin
              conflict_q <= conflict_q + CNT_ONE;
            end
          end else if (last_word) begin
            state_q <= S_DONE;
          end else begin
            word_idx_q <= word_idx_q + WIDX_ONE;
            state_q    <= S_COLLECT;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ld_ready     = (state_q == S_COLLECT);
  assign ld_busy      = (state_q != S_IDLE);
  assign ld_done      = (state_q == S_DONE);
  assign cpu_hold     = HOLD_CPU && ld_busy;
  assign conflict_cnt = conflict_q;

  // Write enable is gated by reset directly so nothing reaches IMEM while rst is high.
  assign imem_wea   = rst ? 4'b0000 : (ld_wr ? 4'b1111 : cpu_we);
  assign imem_addra = ld_wr ? ld_addr : cpu_addr;
  assign imem_dina  = ld_wr ? word_q : cpu_din;

endmodule

// File: tb/tb_imem_load_arbiter.sv
module tb_imem_load_arbiter;

  typedef struct packed {
    logic [3:0]  wea;
    logic [11:0] addr;
    logic [31:0] din;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_din;
  logic        ld_start;
  logic [11:0] ld_base;
  logic [12:0] ld_count;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        cpu_hold;
  logic [3:0]  imem_wea;
  logic [11:0] imem_addra;
  logic [31:0] imem_dina;
  logic [15:0] conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  wr_t wr_q[$];
  int  done_q[$];

  imem_load_arbiter #(.ADDR_W(12), .HOLD_CPU(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
    .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done), .cpu_hold(cpu_hold),
    .imem_wea(imem_wea), .imem_addra(imem_addra), .imem_dina(imem_dina),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every port write and every ld_done pulse must match the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_wea != 4'b0000) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", {imem_wea, imem_addra, imem_dina}, 48'h0);
        end else begin
          chk("port_write", {imem_wea, imem_addra, imem_dina}, wr_q.pop_front());
        end
      end
      if (ld_done) begin
        chk("done_expected", done_q.size() > 0, 1'b1);
        if (done_q.size() > 0) void'(done_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [11:0] base, input logic [12:0] count);
    ld_start = 1'b1;
    ld_base  = base;
    ld_count = count;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    ld_byte  = b;
    ld_valid = 1'b1;
    while (!ld_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("ld_ready_wait", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (ld_busy && guard < 50) begin
      tick();
      guard++;
    end
    chk("idle_wait", ld_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_we = 4'hF; cpu_addr = 12'h123; cpu_din = 32'hDEADDEAD;
    ld_start = 1'b0; ld_base = '0; ld_count = '0; ld_byte = '0; ld_valid = 1'b0;
    repeat (2) tick();
    // Reset state, with a CPU store asserted to show wea is forced low.
    chk("rst_wea", imem_wea, 4'h0);
    chk("rst_ready", ld_ready, 1'b0);
    chk("rst_busy", ld_busy, 1'b0);
    chk("rst_done", ld_done, 1'b0);
    chk("rst_hold", cpu_hold, 1'b0);
    chk("rst_conflict", conflict_cnt, 16'd0);
    cpu_we = 4'h0;
    rst = 1'b0;
    tick();

    // T1: two words, no CPU traffic.
    wr_q.push_back('{4'hF, 12'h010, 32'h11223344});
    wr_q.push_back('{4'hF, 12'h011, 32'h55667788});
    done_q.push_back(1);
    start_load(12'h010, 13'd2);
    chk("t1_hold", cpu_hold, 1'b1);
    send_word(32'h11223344);
    send_word(32'h55667788);
    chk("t1_pend_ready", ld_ready, 1'b0);
    tick();
    chk("t1_done_pulse", ld_done, 1'b1);
    tick();
    chk("t1_done_low", ld_done, 1'b0);
    chk("t1_busy_low", ld_busy, 1'b0);

    // T2: zero-length load goes straight to DONE.
    done_q.push_back(2);
    start_load(12'h100, 13'd0);
    chk("t2_done_pulse", ld_done, 1'b1);
    tick();
    chk("t2_done_low", ld_done, 1'b0);
    repeat (2) tick();

    // T3: CPU stores defer the pending loader word for 3 cycles.
    repeat (3) wr_q.push_back('{4'h8, 12'h005, 32'hAA000000});
    wr_q.push_back('{4'hF, 12'h020, 32'hC1C2C3C4});
    done_q.push_back(3);
    start_load(12'h020, 13'd1);
    send_word(32'hC1C2C3C4);
    cpu_we = 4'b1000; cpu_addr = 12'h005; cpu_din = 32'hAA000000;
    repeat (3) tick();
    cpu_we = 4'h0;
    chk("t3_conflict", conflict_cnt, 16'd3);
    wait_idle();

    // T4: address wrap.
    wr_q.push_back('{4'hF, 12'hFFF, 32'hDEADBEEF});
    wr_q.push_back('{4'hF, 12'h000, 32'h01020304});
    done_q.push_back(4);
    start_load(12'hFFF, 13'd2);
    send_word(32'hDEADBEEF);
    send_word(32'h01020304);
    wait_idle();

    // T5: reset mid-word discards the partial word, then a clean restart.
    start_load(12'h030, 13'd1);
    send_byte(8'hA1);
    send_byte(8'hA2);
    cpu_we = 4'hF;
    rst = 1'b1;
    #1;
    chk("t5_wea", imem_wea, 4'h0);
    chk("t5_busy", ld_busy, 1'b0);
    chk("t5_ready", ld_ready, 1'b0);
    chk("t5_hold", cpu_hold, 1'b0);
    chk("t5_conflict", conflict_cnt, 16'd0);
    tick();
    cpu_we = 4'h0;
    rst = 1'b0;
    tick();
    wr_q.push_back('{4'hF, 12'h040, 32'hB1B2B3B4});
    done_q.push_back(5);
    start_load(12'h040, 13'd1);
    send_word(32'hB1B2B3B4);
    wait_idle();

    // T6: ld_start while busy ignored; ld_valid outside COLLECT not consumed.
    wr_q.push_back('{4'h1, 12'h007, 32'h000000FF});
    wr_q.push_back('{4'hF, 12'h050, 32'h5A5B5C5D});
    done_q.push_back(6);
    start_load(12'h050, 13'd1);
    start_load(12'h060, 13'd5);
    send_word(32'h5A5B5C5D);
    ld_valid = 1'b1; ld_byte = 8'hEE;
    cpu_we = 4'b0001; cpu_addr = 12'h007; cpu_din = 32'h000000FF;
    chk("t6_pend_ready_cpu", ld_ready, 1'b0);
    tick();
    cpu_we = 4'h0;
    chk("t6_pend_ready", ld_ready, 1'b0);
    tick();
    chk("t6_done_ready", ld_ready, 1'b0);
    tick();
    chk("t6_idle_ready", ld_ready, 1'b0);
    chk("t6_conflict", conflict_cnt, 16'd1);
    // Byte presented in the ld_start cycle must not be taken.
    wr_q.push_back('{4'hF, 12'h070, 32'h12345678});
    done_q.push_back(7);
    ld_byte = 8'h99;
    start_load(12'h070, 13'd1);
    send_word(32'h12345678);
    wait_idle();

    repeat (4) tick();
    chk("wr_queue_empty", wr_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
